// File: rtl/mesi_snoop_responder.sv
// Snoop-side MESI responder: answers other caches' bus ops against a local direct-mapped
// tag/MESI table, downgrades or invalidates lines, notifies L1, and streams dirty lines on HITM.
module mesi_snoop_responder #(
  parameter  int NUM_LINES   = 16,
  parameter  int TAG_W       = 8,
  parameter  int FLUSH_BEATS = 4,
  localparam int IDX_W       = $clog2(NUM_LINES),
  localparam int BEAT_W      = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_snp_valid,
  output logic              o_snp_ready,
  input  logic [1:0]        i_snp_op,
  input  logic [IDX_W-1:0]  i_snp_idx,
  input  logic [TAG_W-1:0]  i_snp_tag,
  output logic              o_res_valid,
  output logic [1:0]        o_res_code,
  output logic              o_l1_msg_valid,
  output logic [1:0]        o_l1_msg,
  output logic              o_flush_valid,
  input  logic              i_flush_ready,
  output logic [BEAT_W-1:0] o_flush_beat,
  output logic              o_flush_last,
  input  logic              i_upd_valid,
  output logic              o_upd_ready,
  input  logic [IDX_W-1:0]  i_upd_idx,
  input  logic [TAG_W-1:0]  i_upd_tag,
  input  logic [1:0]        i_upd_state,
  output logic              o_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [1:0] RES_NOHIT = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_HITM  = 2'd2;

  localparam logic [1:0] MSG_GETLINE = 2'd1;
  localparam logic [1:0] MSG_INVLINE = 2'd2;
  localparam logic [1:0] MSG_EVICT   = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FLUSH_BEATS - 1);

  typedef struct packed {
    logic [1:0] code;
    logic       msg_v;
    logic [1:0] msg;
    logic       err;
    logic       wr;
    logic [1:0] nxt;
  } snp_res_t;

  // Protocol table: result, L1 message and new MESI state for one snoop against one entry.
  function automatic snp_res_t snoop_decode(input logic [1:0] op, input logic hit,
                                            input logic [1:0] cur);
    snp_res_t r;
    r     = '0;
    r.nxt = cur;
    if (hit) begin
      case (op)
        OP_READ: begin
          r.code  = (cur == MESI_M) ? RES_HITM : RES_HIT;
          r.msg_v = (cur == MESI_M);
          r.msg   = (cur == MESI_M) ? MSG_GETLINE : 2'd0;
          r.wr    = 1'b1;
          r.nxt   = MESI_S;
        end
        OP_WRITE: r.wr = 1'b0;
        OP_INV: begin
          if (cur == MESI_S) begin
            r.msg_v = 1'b1;
            r.msg   = MSG_INVLINE;
            r.wr    = 1'b1;
            r.nxt   = MESI_I;
          end else begin
            r.err = 1'b1;
          end
        end
        OP_RWIM: begin
          r.code  = (cur == MESI_M) ? RES_HITM : RES_NOHIT;
          r.msg_v = 1'b1;
          r.msg   = (cur == MESI_M) ? MSG_EVICT : MSG_INVLINE;
          r.wr    = 1'b1;
          r.nxt   = MESI_I;
        end
        default: r.wr = 1'b0;
      endcase
    end else begin
      r.wr = 1'b0;
    end
    return r;
  endfunction

  state_e             r_state;
  state_e             w_state_nxt;
  logic [TAG_W-1:0]   r_tag  [NUM_LINES];
  logic [1:0]         r_mesi [NUM_LINES];
  logic [IDX_W-1:0]   r_idx;
  logic               r_wr;
  logic [1:0]         r_nxt;
  logic               r_hitm;
  logic               r_res_valid;
  logic [1:0]         r_res_code;
  logic               r_msg_valid;
  logic [1:0]         r_msg;
  logic               r_err;
  logic               r_flush_valid;
  logic [BEAT_W-1:0]  r_beat;

  logic               w_accept;
  logic               w_upd_fire;
  logic               w_fwd;
  logic [TAG_W-1:0]   w_cur_tag;
  logic [1:0]         w_cur_st;
  logic               w_hit;
  snp_res_t           w_dec;
  logic               w_beat_fire;

  assign o_snp_ready  = (r_state == ST_IDLE);
  assign o_upd_ready  = (r_state != ST_LOOKUP);
  assign w_accept     = i_snp_valid && o_snp_ready;
  assign w_upd_fire   = i_upd_valid && o_upd_ready;
  // An update landing in the accept cycle is forwarded so the lookup sees it.
  assign w_fwd        = w_upd_fire && (i_upd_idx == i_snp_idx);
  assign w_cur_tag    = w_fwd ? i_upd_tag   : r_tag[i_snp_idx];
  assign w_cur_st     = w_fwd ? i_upd_state : r_mesi[i_snp_idx];
  assign w_hit        = (w_cur_st != MESI_I) && (w_cur_tag == i_snp_tag);
  assign w_dec        = snoop_decode(i_snp_op, w_hit, w_cur_st);
  assign w_beat_fire  = r_flush_valid && i_flush_ready;

  assign o_res_valid    = r_res_valid;
  assign o_res_code     = r_res_code;
  assign o_l1_msg_valid = r_msg_valid;
  assign o_l1_msg       = r_msg;
  assign o_err          = r_err;
  assign o_flush_valid  = r_flush_valid;
  assign o_flush_beat   = r_beat;
  assign o_flush_last   = r_flush_valid && (r_beat == LAST_BEAT);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_LOOKUP;
        else          w_state_nxt = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (r_hitm) w_state_nxt = ST_FLUSH;
        else        w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_beat_fire && (r_beat == LAST_BEAT)) w_state_nxt = ST_IDLE;
        else                                      w_state_nxt = ST_FLUSH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tag/state table: snoop write-back at the end of LOOKUP, otherwise local updates.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_mesi[i] <= MESI_I;
      end
    end else if ((r_state == ST_LOOKUP) && r_wr) begin
      r_mesi[r_idx] <= r_nxt;
    end else if (w_upd_fire) begin
      r_tag[i_upd_idx]  <= i_upd_tag;
      r_mesi[i_upd_idx] <= i_upd_state;
    end
  end

  // Snoop result is decided at accept and presented for exactly the LOOKUP cycle.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_res_valid <= 1'b0;
      r_res_code  <= 2'd0;
      r_msg_valid <= 1'b0;
      r_msg       <= 2'd0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wr        <= 1'b0;
      r_nxt       <= 2'd0;
      r_hitm      <= 1'b0;
    end else begin
      r_res_valid <= w_accept;
      r_res_code  <= w_accept ? w_dec.code : 2'd0;
      r_msg_valid <= w_accept && w_dec.msg_v;
      r_msg       <= (w_accept && w_dec.msg_v) ? w_dec.msg : 2'd0;
      r_err       <= w_accept && w_dec.err;
      if (w_accept) begin
        r_idx  <= i_snp_idx;
        r_wr   <= w_dec.wr;
        r_nxt  <= w_dec.nxt;
        r_hitm <= (w_dec.code == RES_HITM);
      end
    end
  end

  // Write-back beat sequencer.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_flush_valid <= 1'b0;
      r_beat        <= '0;
    end else if (r_state == ST_LOOKUP) begin
      r_flush_valid <= r_hitm;
      r_beat        <= '0;
    end else if (w_beat_fire) begin
      if (r_beat == LAST_BEAT) begin
        r_flush_valid <= 1'b0;
        r_beat        <= '0;
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Scoreboard bench for mesi_snoop_responder: directed protocol cases plus random traffic
// checked against a table-level MESI model.
module tb_mesi_snoop_responder;
  localparam int FB = 4;

  logic       i_clk = 1'b0;
  logic       i_rstb;
  logic       i_snp_valid;
  logic       o_snp_ready;
  logic [1:0] i_snp_op;
  logic [3:0] i_snp_idx;
  logic [7:0] i_snp_tag;
  logic       o_res_valid;
  logic [1:0] o_res_code;
  logic       o_l1_msg_valid;
  logic [1:0] o_l1_msg;
  logic       o_flush_valid;
  logic       i_flush_ready;
  logic [1:0] o_flush_beat;
  logic       o_flush_last;
  logic       i_upd_valid;
  logic       o_upd_ready;
  logic [3:0] i_upd_idx;
  logic [7:0] i_upd_tag;
  logic [1:0] i_upd_state;
  logic       o_err;

  mesi_snoop_responder dut (
    .i_clk(i_clk), .i_rstb(i_rstb),
    .i_snp_valid(i_snp_valid), .o_snp_ready(o_snp_ready), .i_snp_op(i_snp_op),
    .i_snp_idx(i_snp_idx), .i_snp_tag(i_snp_tag),
    .o_res_valid(o_res_valid), .o_res_code(o_res_code),
    .o_l1_msg_valid(o_l1_msg_valid), .o_l1_msg(o_l1_msg),
    .o_flush_valid(o_flush_valid), .i_flush_ready(i_flush_ready),
    .o_flush_beat(o_flush_beat), .o_flush_last(o_flush_last),
    .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready), .i_upd_idx(i_upd_idx),
    .i_upd_tag(i_upd_tag), .i_upd_state(i_upd_state), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int code;
    int msgv;
    int msg;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   m_tag[16];
  int   m_st[16];
  int   checks = 0;
  int   errors = 0;
  int   flush_pend = 0;
  int   exp_beat = 0;
  int   fr_mode = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = 0;
      m_st[i]  = 0;
    end
  endtask

  // MESI states 0=I 1=S 2=E 3=M; codes 0=NOHIT 1=HIT 2=HITM; msgs 1=GET 2=INV 3=EVICT.
  task automatic model_snoop(input int op, input int idx, input int tag);
    exp_t e;
    int   st;
    bit   hit;
    st  = m_st[idx];
    hit = (st != 0) && (m_tag[idx] == tag);
    e.code = 0; e.msgv = 0; e.msg = 0; e.err = 0;
    if (hit) begin
      if (op == 0) begin
        e.code = (st == 3) ? 2 : 1;
        if (st == 3) begin e.msgv = 1; e.msg = 1; end
        m_st[idx] = 1;
      end else if (op == 2) begin
        if (st == 1) begin e.msgv = 1; e.msg = 2; m_st[idx] = 0; end
        else e.err = 1;
      end else if (op == 3) begin
        e.msgv = 1;
        if (st == 3) begin e.code = 2; e.msg = 3; end
        else e.msg = 2;
        m_st[idx] = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic upd(input int idx, input int tag, input int st);
    int n = 0;
    i_upd_valid = 1'b1; i_upd_idx = 4'(idx); i_upd_tag = 8'(tag); i_upd_state = 2'(st);
    while (!o_upd_ready && n < 300) begin @(posedge i_clk); #1; n++; end
    if (n >= 300) chk(1'b0, "upd_ready_timeout", 0, 1);
    m_tag[idx] = tag;
    m_st[idx]  = st;
    @(posedge i_clk); #1;
    i_upd_valid = 1'b0;
  endtask

  task automatic snoop(input int op, input int idx, input int tag);
    int n = 0;
    i_snp_valid = 1'b1; i_snp_op = 2'(op); i_snp_idx = 4'(idx); i_snp_tag = 8'(tag);
    while (!o_snp_ready && n < 300) begin @(posedge i_clk); #1; n++; end
    if (n >= 300) chk(1'b0, "snp_ready_timeout", 0, 1);
    model_snoop(op, idx, tag);
    @(posedge i_clk); #1;
    i_snp_valid = 1'b0;
  endtask

  task automatic upd_and_snoop(input int idx, input int tag, input int st, input int op);
    int n = 0;
    i_upd_valid = 1'b1; i_upd_idx = 4'(idx); i_upd_tag = 8'(tag); i_upd_state = 2'(st);
    i_snp_valid = 1'b1; i_snp_op = 2'(op); i_snp_idx = 4'(idx); i_snp_tag = 8'(tag);
    while (!o_snp_ready && n < 300) begin @(posedge i_clk); #1; n++; end
    if (n >= 300) chk(1'b0, "combo_timeout", 0, 1);
    m_tag[idx] = tag;
    m_st[idx]  = st;
    model_snoop(op, idx, tag);
    @(posedge i_clk); #1;
    i_upd_valid = 1'b0;
    i_snp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!o_snp_ready || o_flush_valid) && n < 300) begin @(posedge i_clk); #1; n++; end
    if (n >= 300) chk(1'b0, "idle_timeout", 0, 1);
  endtask

  // Bus-side acceptance of write-back beats.
  initial begin : fr_drv
    int stalls;
    stalls = 0;
    i_flush_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      if (fr_mode == 1) i_flush_ready = ($urandom_range(0, 3) != 0);
      else if (fr_mode == 2 && o_flush_valid && o_flush_beat == 2'd1 && stalls < 3) begin
        i_flush_ready = 1'b0;
        stalls++;
      end else i_flush_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each result and tracks write-back beats.
  initial begin : monitor
    exp_t e;
    bit   lv, lr;
    int   lb;
    lv = 1'b0; lr = 1'b0; lb = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rstb) begin
        exp_q.delete();
        flush_pend = 0; exp_beat = 0; lv = 1'b0; lr = 1'b0;
      end else begin
        if (o_res_valid) begin
          chk(!o_snp_ready && !o_upd_ready, "lookup_readies", {o_snp_ready, o_upd_ready}, 0);
          if (exp_q.size() == 0) chk(1'b0, "unexpected_res", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk(o_res_code == e.code, "res_code", o_res_code, e.code);
            chk(o_l1_msg_valid == e.msgv, "l1_msg_valid", o_l1_msg_valid, e.msgv);
            if (e.msgv != 0) chk(o_l1_msg == e.msg, "l1_msg", o_l1_msg, e.msg);
            chk(o_err == e.err, "err", o_err, e.err);
            if (e.code == 2) flush_pend++;
          end
        end else begin
          chk(o_res_code == 2'd0 && !o_l1_msg_valid && !o_err, "quiet_outputs",
              {o_res_code, o_l1_msg_valid, o_err}, 0);
        end
        if (flush_pend > 0) chk(!o_snp_ready, "snp_ready_during_flush", o_snp_ready, 0);
        if (lv && !lr) chk(o_flush_valid && o_flush_beat == 2'(lb), "beat_hold", o_flush_beat, lb);
        if (o_flush_valid) begin
          chk(o_upd_ready, "upd_ready_in_flush", o_upd_ready, 1);
          chk(o_flush_last == (o_flush_beat == 2'(FB - 1)), "flush_last", o_flush_last,
              (o_flush_beat == 2'(FB - 1)));
          if (flush_pend == 0) chk(1'b0, "unexpected_flush", 1, 0);
          else if (i_flush_ready) begin
            chk(o_flush_beat == 2'(exp_beat), "flush_beat", o_flush_beat, exp_beat);
            exp_beat++;
            if (exp_beat == FB) begin exp_beat = 0; flush_pend--; end
          end
        end
        lv = o_flush_valid; lr = i_flush_ready; lb = o_flush_beat;
      end
    end
  end

  initial begin : main
    int n;
    i_rstb = 1'b0; i_snp_valid = 1'b0; i_snp_op = 2'd0; i_snp_idx = 4'd0; i_snp_tag = 8'd0;
    i_upd_valid = 1'b0; i_upd_idx = 4'd0; i_upd_tag = 8'd0; i_upd_state = 2'd0;
    model_reset();
    #2;
    chk(o_snp_ready && o_upd_ready, "reset_readies", {o_snp_ready, o_upd_ready}, 3);
    chk(!o_res_valid && !o_l1_msg_valid && !o_err, "reset_pulses",
        {o_res_valid, o_l1_msg_valid, o_err}, 0);
    chk(!o_flush_valid && o_flush_beat == 2'd0, "reset_flush", {o_flush_valid, o_flush_beat}, 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rstb = 1'b1;

    snoop(0, 3, 8'h12);
    wait_idle();
    upd(3, 8'h12, 3);
    snoop(0, 3, 8'h12);
    snoop(0, 3, 8'h12);

    fr_mode = 2;
    upd(3, 8'h12, 3);
    snoop(0, 3, 8'h12);
    wait_idle();
    fr_mode = 0;

    upd(5, 8'h01, 2);
    snoop(3, 5, 8'h01);
    snoop(0, 5, 8'h01);
    upd(5, 8'h01, 3);
    snoop(3, 5, 8'h01);
    snoop(0, 5, 8'h01);

    upd(5, 8'h01, 3);
    snoop(0, 5, 8'h02);
    snoop(2, 5, 8'h01);
    snoop(1, 5, 8'h01);
    snoop(0, 5, 8'h01);
    upd(6, 8'h07, 1);
    snoop(2, 6, 8'h07);
    snoop(0, 6, 8'h07);

    upd_and_snoop(9, 8'h44, 3, 0);
    wait_idle();

    fr_mode = 1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 4)
        upd($urandom_range(0, 3), $urandom_range(1, 2), $urandom_range(0, 3));
      else
        snoop($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 2));
    end
    wait_idle();
    fr_mode = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    chk(flush_pend == 0, "flushes_completed", flush_pend, 0);

    upd(7, 8'h33, 3);
    snoop(0, 7, 8'h33);
    n = 0;
    while (!(o_flush_valid && o_flush_beat == 2'd2) && n < 50) begin @(posedge i_clk); #1; n++; end
    if (n >= 50) chk(1'b0, "beat2_timeout", 0, 1);
    #2;
    i_rstb = 1'b0;
    model_reset();
    #1;
    chk(!o_flush_valid && o_flush_beat == 2'd0, "reset_abort_flush", {o_flush_valid, o_flush_beat}, 0);
    chk(o_snp_ready && o_upd_ready, "reset_abort_readies", {o_snp_ready, o_upd_ready}, 3);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rstb = 1'b1;
    #1;
    chk(o_snp_ready && !o_flush_valid, "post_reset_idle", {o_snp_ready, o_flush_valid}, 2);
    snoop(0, 7, 8'h33);
    wait_idle();
    repeat (3) @(posedge i_clk);
    #1;
    chk(exp_q.size() == 0, "final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
